riscv_sim_ctrl: RTL and testbench
=================================

Name: riscv_sim_ctrl

Overview:
- Parametrised, synthesizable run controller for the RV32I pipeline bench; replaces the fixed reset-then-run-N-cycles bench sequence.
- Generates the core reset and counts run cycles.
- Snoops the M-stage store bus for a tohost write and reports pass, fail, timeout or hang.
- Sits between the bench top (or an FPGA wrapper) and riscv_top. The bench only pulses start and waits for done.

Parameters:
- XLEN, 32, data/address width of the snooped bus.
- RST_CYCLES, 4, cycles the core reset is held low after start (>=1).
- TIMEOUT, 200, max RUN cycles before timeout (>=2).
- HANG_CYCLES, 16, consecutive RUN cycles with unchanged fetch PC that declare a hang (>=2; 0 disables).
- TOHOST_ADDR, 32'h0000_0100, word address of the tohost location.
- CNT_W, 16, width of the cycle counter.

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle start/restart pulse.
- i_pc_f  in  XLEN  core fetch PC.
- i_mem_write_m  in  1  M-stage store enable.
- i_mem_byte_sel_m  in  4  M-stage byte enables.
- i_alu_result_m  in  XLEN  M-stage store address.
- i_write_data_m  in  XLEN  M-stage store data.
- o_core_rstn  out  1  reset to riscv_top; active low.
- o_busy  out  1  high in RESET and RUN.
- o_done  out  1  high in any terminal state.
- o_pass  out  1  terminal: PASS.
- o_fail  out  1  terminal: FAIL.
- o_timeout  out  1  terminal: TIMEOUT.
- o_hang  out  1  terminal: HANG.
- o_fail_code  out  XLEN-1  test number reported on FAIL (data>>1).
- o_cycle_cnt  out  CNT_W  RUN cycles elapsed; saturating.

Behaviour:
- Interface: one clock. Reset is asynchronous and active-low; clock is i_clk, reset is i_rstn.
- Reset values:
  - State = IDLE.
  - o_core_rstn = 0.
  - All status outputs = 0.
  - o_fail_code = 0, o_cycle_cnt = 0.
  - Reset counter, hang counter and last-PC register = 0.
- States: IDLE, RESET, RUN, PASS, FAIL, TIMEOUT, HANG. All outputs are registered.
- IDLE / terminal states:
  - i_start -> RESET.
  - Entering RESET clears o_cycle_cnt, o_fail_code, all status flags, the hang counter and the reset counter.
- RESET:
  - o_core_rstn = 0, o_busy = 1.
  - After exactly RST_CYCLES cycles in RESET -> RUN.
  - o_core_rstn rises on the first RUN cycle.
- RUN:
  - o_core_rstn = 1.
  - o_cycle_cnt increments every cycle and saturates at all-ones.
  - i_start is ignored.
- tohost hit:
  - Condition: i_mem_write_m && i_mem_byte_sel_m == 4'b1111 && i_alu_result_m == TOHOST_ADDR.
  - Evaluated only in RUN.
  - Data == 1 -> PASS.
  - Data[0] == 1 and data != 1 -> FAIL, with o_fail_code = data[XLEN-1:1].
  - Data[0] == 0 -> ignored; RUN continues.
  - Partial-byte stores to TOHOST_ADDR are ignored.
- Hang detection:
  - Each RUN cycle: if i_pc_f == last PC, the hang counter increments; otherwise it clears to 0. Last PC updates every cycle.
  - Hang counter reaching HANG_CYCLES-1 with an equal PC -> HANG.
  - The pipeline stall window (<=2 cycles) must not trigger this.
- Timeout: o_cycle_cnt == TIMEOUT-1 with no other terminal event that cycle -> TIMEOUT.
- Priority for same-cycle events: tohost > hang > timeout.
- Terminal states:
  - Exactly one of pass/fail/timeout/hang is set. o_done = 1, o_busy = 0.
  - o_core_rstn = 0 to freeze the core.
  - o_cycle_cnt holds its value.
  - Outputs are sticky until the next i_start or i_rstn.
- Latency:
  - Terminal flags assert the cycle after the detecting edge.
  - o_cycle_cnt includes the detecting cycle.
- i_rstn asserted mid-run: immediate return to IDLE with reset values; o_core_rstn drops asynchronously.
- i_start during RESET restarts the reset count. The cycle counter stays cleared.

Test Plan (defaults unless stated):
- Reset, pulse i_start at cycle 0:
  - o_core_rstn low for exactly 4 cycles, then high.
  - o_busy high throughout.
  - o_cycle_cnt = 0 on the first RUN cycle.
- In RUN, drive a store of 32'h1 to 0x100 with byte_sel 4'b1111 at RUN cycle 50:
  - Next cycle: o_pass = 1, o_done = 1, o_core_rstn = 0, o_cycle_cnt = 51.
  - Held stable for 20 cycles.
- Store 32'h7 to 0x100 -> o_fail = 1, o_fail_code = 3.
- Ignored-store checks:
  - Store 32'h1 with byte_sel 4'b0001 -> no change.
  - Store 32'h4 with full byte_sel -> no change.
- No stores, PC toggling -> o_timeout = 1 with o_cycle_cnt = 200.
- PC frozen at 0x40 from RUN cycle 10 -> o_hang = 1 after 16 equal cycles.
- PC equal for 2 cycles -> no hang.
- Priority: tohost pass on the hang-detect cycle -> o_pass only.
- Reset mid-run: assert i_rstn low at RUN cycle 30 -> all outputs zero asynchronously.
- Restart: i_start after PASS -> flags clear, new RESET sequence.

Source files
------------

// File: rtl/riscv_sim_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_sim_ctrl
//
// Run controller for the RV32I pipeline bench. After a start pulse it holds
// the core in reset for RST_CYCLES cycles, releases it, counts run cycles and
// snoops the M-stage store bus for a full-word write to the tohost location.
// The run ends in exactly one terminal state (PASS, FAIL, TIMEOUT or HANG).
// In a terminal state the core is held in reset again and the status is
// sticky until the next start pulse or i_rstn.
//
// Ports
//   i_clk            clock
//   i_rstn           asynchronous active-low reset
//   i_start          single-cycle start / restart pulse
//   i_pc_f           core fetch PC (hang detection)
//   i_mem_write_m    M-stage store enable
//   i_mem_byte_sel_m M-stage byte enables
//   i_alu_result_m   M-stage store address
//   i_write_data_m   M-stage store data
//   o_core_rstn      reset to the core, active low
//   o_busy           high in RESET and RUN
//   o_done           high in any terminal state
//   o_pass/o_fail/o_timeout/o_hang  terminal status, one-hot when o_done
//   o_fail_code      test number reported on FAIL (store data >> 1)
//   o_cycle_cnt      RUN cycles elapsed, saturating
// -----------------------------------------------------------------------------
module riscv_sim_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              TIMEOUT     = 200,
  parameter int              HANG_CYCLES = 16,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h0000_0100,
  parameter int              CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_start,
  input  logic [XLEN-1:0]  i_pc_f,
  input  logic             i_mem_write_m,
  input  logic [3:0]       i_mem_byte_sel_m,
  input  logic [XLEN-1:0]  i_alu_result_m,
  input  logic [XLEN-1:0]  i_write_data_m,
  output logic             o_core_rstn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_fail,
  output logic             o_timeout,
  output logic             o_hang,
  output logic [XLEN-2:0]  o_fail_code,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int HW = (HANG_CYCLES > 1) ? $clog2(HANG_CYCLES) : 1;

  localparam bit               HANG_EN   = (HANG_CYCLES != 0);
  localparam logic [RW-1:0]    RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [HW-1:0]    HANG_LAST = HW'((HANG_CYCLES > 0) ? HANG_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT,
    S_HANG
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [RW-1:0]    r_rst_cnt, w_rst_cnt_nxt;
  logic [HW-1:0]    r_hang_cnt, w_hang_cnt_nxt;
  logic [XLEN-1:0]  r_last_pc;
  logic [CNT_W-1:0] r_cycle_cnt, w_cycle_cnt_nxt;
  logic [XLEN-2:0]  r_fail_code, w_fail_code_nxt;
  logic             r_core_rstn, r_busy, r_done, r_pass, r_fail, r_timeout, r_hang;

  logic w_tohost_hit;
  logic w_pc_eq;

  // Only a full-word store to tohost counts; byte/half stores there are noise.
  assign w_tohost_hit = i_mem_write_m && (i_mem_byte_sel_m == 4'b1111) &&
                        (i_alu_result_m == TOHOST_ADDR);
  assign w_pc_eq      = (i_pc_f == r_last_pc);

  // ---------------------------------------------------------------------------
  // Next-state and next-value logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_rst_cnt_nxt   = r_rst_cnt;
    w_hang_cnt_nxt  = r_hang_cnt;
    w_cycle_cnt_nxt = r_cycle_cnt;
    w_fail_code_nxt = r_fail_code;

    case (r_state)
      S_RESET: begin
        if (i_start) begin
          // Restart re-arms the full reset window.
          w_rst_cnt_nxt = '0;
        end else if (r_rst_cnt == RST_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RW'(1);
        end
      end

      S_RUN: begin
        // The detecting cycle is included in the final count.
        w_cycle_cnt_nxt = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);
        w_hang_cnt_nxt  = (HANG_EN && w_pc_eq) ? r_hang_cnt + HW'(1) : '0;

        // Same-cycle priority: tohost, then hang, then timeout.
        if (w_tohost_hit && (i_write_data_m == XLEN'(1))) begin
          w_state_nxt = S_PASS;
        end else if (w_tohost_hit && i_write_data_m[0]) begin
          w_state_nxt     = S_FAIL;
          w_fail_code_nxt = i_write_data_m[XLEN-1:1];
        end else if (HANG_EN && w_pc_eq && (r_hang_cnt == HANG_LAST)) begin
          w_state_nxt = S_HANG;
        end else if (r_cycle_cnt == TMO_LAST) begin
          w_state_nxt = S_TIMEOUT;
        end
      end

      default: begin
        // IDLE and all terminal states wait for a start pulse.
        if (i_start) begin
          w_state_nxt     = S_RESET;
          w_rst_cnt_nxt   = '0;
          w_hang_cnt_nxt  = '0;
          w_cycle_cnt_nxt = '0;
          w_fail_code_nxt = '0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. Status outputs are decoded from the next
  // state so that they change on the same edge as the state itself.
  // ---------------------------------------------------------------------------
  // NOTE: every register, including the last-PC snapshot, takes a defined
  // value on reset; there is no storage here large enough to leave unreset.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_rst_cnt   <= '0;
      r_hang_cnt  <= '0;
      r_last_pc   <= '0;
      r_cycle_cnt <= '0;
      r_fail_code <= '0;
      r_core_rstn <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail      <= 1'b0;
      r_timeout   <= 1'b0;
      r_hang      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state     <= w_state_nxt;
      r_rst_cnt   <= w_rst_cnt_nxt;
      r_hang_cnt  <= w_hang_cnt_nxt;
      r_last_pc   <= i_pc_f;
      r_cycle_cnt <= w_cycle_cnt_nxt;
      r_fail_code <= w_fail_code_nxt;
      r_core_rstn <= (w_state_nxt == S_RUN);
      r_busy      <= (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
      r_done      <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) ||
                     (w_state_nxt == S_TIMEOUT) || (w_state_nxt == S_HANG);
      r_pass      <= (w_state_nxt == S_PASS);
      r_fail      <= (w_state_nxt == S_FAIL);
      r_timeout   <= (w_state_nxt == S_TIMEOUT);
      r_hang      <= (w_state_nxt == S_HANG);
    end
  end

  assign o_core_rstn = r_core_rstn;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_fail      = r_fail;
  assign o_timeout   = r_timeout;
  assign o_hang      = r_hang;
  assign o_fail_code = r_fail_code;
  assign o_cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_riscv_sim_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for riscv_sim_ctrl. Each run is described as a per-RUN-cycle
// program (fetch PC and store bus). A reference model walks the program with
// the controller's rules and pushes the expected terminal outcome into a
// queue; a monitor pops and compares when the DUT raises o_done.
// -----------------------------------------------------------------------------
module tb_riscv_sim_ctrl;

  localparam int          XLEN        = 32;
  localparam int          RST_CYCLES  = 4;
  localparam int          TIMEOUT     = 200;
  localparam int          HANG_CYCLES = 16;
  localparam logic [31:0] TOHOST      = 32'h0000_0100;
  localparam int          CNT_W       = 16;
  localparam logic [31:0] IDLE_PC     = 32'hFFFF_FFF0;

  logic             i_clk, i_rstn, i_start;
  logic [XLEN-1:0]  i_pc_f;
  logic             i_mem_write_m;
  logic [3:0]       i_mem_byte_sel_m;
  logic [XLEN-1:0]  i_alu_result_m, i_write_data_m;
  logic             o_core_rstn, o_busy, o_done, o_pass, o_fail, o_timeout, o_hang;
  logic [XLEN-2:0]  o_fail_code;
  logic [CNT_W-1:0] o_cycle_cnt;

  riscv_sim_ctrl #(
    .XLEN(XLEN), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT),
    .HANG_CYCLES(HANG_CYCLES), .TOHOST_ADDR(TOHOST), .CNT_W(CNT_W)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_pc_f(i_pc_f),
    .i_mem_write_m(i_mem_write_m), .i_mem_byte_sel_m(i_mem_byte_sel_m),
    .i_alu_result_m(i_alu_result_m), .i_write_data_m(i_write_data_m),
    .o_core_rstn(o_core_rstn), .o_busy(o_busy), .o_done(o_done),
    .o_pass(o_pass), .o_fail(o_fail), .o_timeout(o_timeout), .o_hang(o_hang),
    .o_fail_code(o_fail_code), .o_cycle_cnt(o_cycle_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Program for one run, indexed by RUN cycle.
  logic [31:0] p_pc   [TIMEOUT];
  logic        p_we   [TIMEOUT];
  logic [3:0]  p_bsel [TIMEOUT];
  logic [31:0] p_addr [TIMEOUT];
  logic [31:0] p_data [TIMEOUT];
  int          p_start_k;

  // flags = {pass, fail, timeout, hang}
  typedef struct {
    logic [3:0]  flags;
    logic [30:0] code;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic done_q   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: walk the program cycle by cycle and return the first
  // terminal event. eq_run is the length of the current run of RUN cycles in
  // which the PC repeated the previous one.
  // ---------------------------------------------------------------------------
  function automatic exp_t model();
    exp_t e;
    int   eq_run;
    bit   eq, hit;
    e.flags = 4'b0000;
    e.code  = '0;
    e.cnt   = 0;
    eq_run  = 0;
    for (int k = 0; k < TIMEOUT; k++) begin
      eq     = (k > 0) && (p_pc[k] == p_pc[k-1]);
      hit    = p_we[k] && (p_bsel[k] == 4'hF) && (p_addr[k] == TOHOST);
      eq_run = eq ? eq_run + 1 : 0;
      e.cnt  = k + 1;
      if (hit && p_data[k] == 32'd1) begin
        e.flags = 4'b1000; return e;
      end
      if (hit && p_data[k][0]) begin
        e.flags = 4'b0100; e.code = p_data[k][31:1]; return e;
      end
      if (HANG_CYCLES != 0 && eq_run >= HANG_CYCLES) begin
        e.flags = 4'b0001; return e;
      end
      if (k == TIMEOUT - 1) begin
        e.flags = 4'b0010; return e;
      end
    end
    return e;
  endfunction

  // Monitor: compare on each rising o_done, sampled on the falling clock edge.
  always @(negedge i_clk) begin
    if (o_done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("mon_flags", {o_pass, o_fail, o_timeout, o_hang}, e.flags);
        check("mon_cycle_cnt", o_cycle_cnt, e.cnt);
        check("mon_fail_code", o_fail_code, e.code);
        check("mon_core_busy", {o_core_rstn, o_busy}, 2'b00);
      end
    end
    done_q <= o_done;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All tasks start and end at posedge + #1.
  // ---------------------------------------------------------------------------
  task automatic drive_idle();
    i_pc_f = IDLE_PC; i_mem_write_m = 1'b0; i_mem_byte_sel_m = 4'h0;
    i_alu_result_m = '0; i_write_data_m = '0;
  endtask

  task automatic drive_k(input int k);
    i_pc_f = p_pc[k]; i_mem_write_m = p_we[k]; i_mem_byte_sel_m = p_bsel[k];
    i_alu_result_m = p_addr[k]; i_write_data_m = p_data[k];
  endtask

  task automatic prog_clear(input logic [31:0] base);
    for (int k = 0; k < TIMEOUT; k++) begin
      p_pc[k] = base + 32'(4 * k);
      p_we[k] = 1'b0; p_bsel[k] = 4'h0; p_addr[k] = '0; p_data[k] = '0;
    end
    p_start_k = -1;
  endtask

  task automatic put_store(input int k, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
    p_we[k] = 1'b1; p_bsel[k] = sel; p_addr[k] = addr; p_data[k] = data;
  endtask

  task automatic freeze_pc(input int from, input logic [31:0] pc);
    for (int k = from; k < TIMEOUT; k++) p_pc[k] = pc;
  endtask

  // Start pulse and RESET window; restart_at >= 0 re-pulses start that many
  // cycles into RESET.
  task automatic reset_seq(input int restart_at);
    int lows, exp_lows;
    bit busy_ok;
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    check("rst_entry_status", {o_busy, o_done, o_pass, o_fail, o_timeout, o_hang, o_core_rstn}, 7'b1000000);
    check("rst_entry_counts", {o_cycle_cnt, 1'b0, o_fail_code}, 0);
    lows = 0; busy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (o_core_rstn) break;
      lows++;
      if (!o_busy) busy_ok = 1'b0;
      i_start = (i == restart_at);
      @(posedge i_clk); #1;
    end
    i_start = 1'b0;
    exp_lows = (restart_at < 0) ? RST_CYCLES : restart_at + 1 + RST_CYCLES;
    check("rst_low_cycles", lows, exp_lows);
    check("rst_busy_held", busy_ok, 1);
    check("run_first_cycle", {o_core_rstn, o_busy, o_done, o_cycle_cnt}, {3'b110, 16'd0});
  endtask

  task automatic run_prog(input int hold);
    exp_t e;
    int   k;
    bit   done_seen;
    e = model();
    exp_q.push_back(e);
    k = 0; done_seen = 1'b0;
    while (k < TIMEOUT + 4 && !done_seen) begin
      if (k < TIMEOUT) drive_k(k); else drive_idle();
      i_start = (k == p_start_k);
      @(posedge i_clk); #1;
      if (o_done) done_seen = 1'b1;
      k++;
    end
    drive_idle();
    i_start = 1'b0;
    check("run_done_bound", done_seen, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk); #1;
      check("sticky_status", {o_done, o_pass, o_fail, o_timeout, o_hang, o_core_rstn, o_busy},
            {1'b1, e.flags, 2'b00});
      check("sticky_cnt", o_cycle_cnt, e.cnt);
    end
  endtask

  task automatic scenario(input int restart_at, input int hold);
    reset_seq(restart_at);
    run_prog(hold);
  endtask

  task automatic random_prog();
    int c;
    prog_clear(32'h1000 + 32'($urandom_range(0, 255)) * 16);
    for (int k = 1; k < TIMEOUT; k++)
      p_pc[k] = ($urandom_range(0, 99) < 12) ? p_pc[k-1] : p_pc[k-1] + 32'd4;
    if ($urandom_range(0, 3) == 0) begin
      c = $urandom_range(0, TIMEOUT - 1);
      freeze_pc(c, p_pc[c]);
    end
    for (int k = 0; k < TIMEOUT; k++) begin
      if ($urandom_range(0, 5) == 0) begin
        p_we[k]   = 1'b1;
        p_addr[k] = ($urandom_range(0, 19) == 0) ? TOHOST : 32'h200 + 32'($urandom_range(0, 63)) * 4;
        p_bsel[k] = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        c = $urandom_range(0, 2);
        p_data[k] = (c == 0) ? 32'd1 : (c == 1) ? ($urandom | 32'd1) : ($urandom & ~32'd1);
      end
    end
    if ($urandom_range(0, 1) == 0) p_start_k = $urandom_range(0, TIMEOUT - 1);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_rstn = 1'b0; i_start = 1'b0;
    drive_idle();
    #17;
    check("reset_status", {o_core_rstn, o_busy, o_done, o_pass, o_fail, o_timeout, o_hang}, 7'b0);
    check("reset_counts", {o_cycle_cnt, 1'b0, o_fail_code}, 0);
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check("idle_after_reset", {o_core_rstn, o_busy, o_done}, 3'b000);

    // PASS at RUN cycle 50, held for 20 cycles.
    prog_clear(32'h1000);
    put_store(50, TOHOST, 4'hF, 32'd1);
    scenario(-1, 20);
    check("pass_cnt_51", o_cycle_cnt, 51);

    // FAIL with data 7 -> code 3; also exercises restart after PASS.
    prog_clear(32'h1000);
    put_store(37, TOHOST, 4'hF, 32'd7);
    scenario(-1, 2);
    check("fail_code_3", o_fail_code, 3);

    // Ignored stores: partial byte, even data, wrong address; then PASS.
    prog_clear(32'h1000);
    put_store(20, TOHOST, 4'b0001, 32'd1);
    put_store(30, TOHOST, 4'hF, 32'd4);
    put_store(40, TOHOST + 32'd4, 4'hF, 32'd1);
    put_store(60, TOHOST, 4'hF, 32'd1);
    scenario(-1, 0);

    // Timeout with toggling PC.
    prog_clear(32'h1000);
    for (int k = 0; k < TIMEOUT; k++) p_pc[k] = k[0] ? 32'h2004 : 32'h2000;
    scenario(-1, 2);
    check("timeout_cnt_200", o_cycle_cnt, 200);

    // Hang: PC frozen at 0x40 from RUN cycle 10.
    prog_clear(32'h1000);
    freeze_pc(10, 32'h40);
    scenario(-1, 2);

    // Repeated two-cycle stalls must not hang; PASS later.
    prog_clear(32'h1000);
    for (int k = 5; k + 2 < TIMEOUT; k += 10) begin
      p_pc[k+1] = p_pc[k]; p_pc[k+2] = p_pc[k];
    end
    put_store(150, TOHOST, 4'hF, 32'd1);
    scenario(-1, 0);

    // Priority: tohost on the hang-detect cycle.
    prog_clear(32'h1000);
    freeze_pc(10, 32'h40);
    put_store(26, TOHOST, 4'hF, 32'd1);
    scenario(-1, 0);
    prog_clear(32'h1000);
    freeze_pc(10, 32'h40);
    put_store(26, TOHOST, 4'hF, 32'd5);
    scenario(-1, 0);

    // Priority: hang on the timeout cycle.
    prog_clear(32'h1000);
    freeze_pc(TIMEOUT - 17, 32'h80);
    scenario(-1, 0);

    // Restart during RESET, and start ignored during RUN.
    prog_clear(32'h1000);
    put_store(5, TOHOST, 4'hF, 32'd1);
    scenario(1, 0);
    prog_clear(32'h1000);
    p_start_k = 40;
    put_store(80, TOHOST, 4'hF, 32'd1);
    scenario(-1, 0);

    // Asynchronous reset at RUN cycle 30.
    prog_clear(32'h1000);
    reset_seq(-1);
    for (int k = 0; k < 30; k++) begin
      drive_k(k);
      @(posedge i_clk); #1;
    end
    drive_k(30);
    #2 i_rstn = 1'b0;
    #1;
    check("async_rst_status", {o_core_rstn, o_busy, o_done, o_pass, o_fail, o_timeout, o_hang}, 7'b0);
    check("async_rst_counts", {o_cycle_cnt, 1'b0, o_fail_code}, 0);
    drive_idle();
    @(negedge i_clk); i_rstn = 1'b1;
    @(posedge i_clk); #1;
    check("idle_after_async", {o_core_rstn, o_busy, o_done}, 3'b000);

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      random_prog();
      scenario(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, RST_CYCLES - 1)) : -1, 1);
    end

    repeat (3) @(posedge i_clk);
    #1;
    check("exp_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
